// File: rtl/painterengine_gpu_read_fifo.sv
// Elastic FWFT buffer behind one GPU DMA reader channel; counts a job length and reports done/error.
// One-cycle write latency, no bypass; reader is throttled when full or when the job's words are all accepted.
module painterengine_gpu_read_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int TIMEOUT_BITS = 19
) (
  input  logic                  i_wire_clock,
  input  logic                  i_wire_reset,
  input  logic                  i_wire_start,
  input  logic [31:0]           i_wire_length,
  input  logic [31:0]           i_wire_data,
  input  logic                  i_wire_data_valid,
  output logic                  o_wire_data_next,
  output logic [31:0]           o_wire_data,
  output logic                  o_wire_data_valid,
  input  logic                  i_wire_data_next,
  output logic [DEPTH_LOG2:0]   o_wire_level,
  output logic                  o_wire_done,
  output logic                  o_wire_error,
  output logic [2:0]            o_wire_error_type
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]              state;
  logic [31:0]             length;
  logic [31:0]             in_count;
  logic [31:0]             out_count;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     level;
  logic [TIMEOUT_BITS-1:0] stall;
  logic [2:0]              err_type;
  logic [31:0]             mem [DEPTH];

  logic busy, full, push, pop, stall_wait, in_last, out_last;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign full = (level == FULL_LVL);

  // Ready depends only on registered state so the reader never sees a combinational loop.
  assign o_wire_data_next  = (state == S_RUN) && !full && (in_count < length);
  assign o_wire_data_valid = busy && (level != '0);
  assign o_wire_data       = mem[rd_ptr];
  assign o_wire_level      = level;
  assign o_wire_done       = (state == S_DONE);
  assign o_wire_error      = (state == S_ERROR);
  assign o_wire_error_type = err_type;

  assign push = i_wire_data_valid && o_wire_data_next;
  assign pop  = o_wire_data_valid && i_wire_data_next;

  assign stall_wait = !push && !pop &&
                      ((o_wire_data_next && !i_wire_data_valid) ||
                       (o_wire_data_valid && !i_wire_data_next));

  // in_count < length whenever push is high, so the +1 cannot wrap.
  assign in_last  = push && ((in_count + 32'd1) == length);
  assign out_last = pop && ((out_count + 32'd1) == length);

  always_ff @(posedge i_wire_clock) begin
    if (push) mem[wr_ptr] <= i_wire_data;
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state     <= S_IDLE;
      length    <= '0;
      in_count  <= '0;
      out_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      stall     <= '0;
      err_type  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + DEPTH_LOG2'(1);
        in_count <= in_count + 32'd1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
        out_count <= out_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      if (!busy || push || pop) stall <= '0;
      else if (stall_wait)      stall <= stall + TIMEOUT_BITS'(1);

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_wire_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_count  <= '0;
            out_count <= '0;
            length    <= i_wire_length;
            if (i_wire_length == 32'd0) begin
              state    <= S_ERROR;
              err_type <= 3'd1;
            end else begin
              state    <= S_RUN;
              err_type <= 3'd0;
            end
          end
        end
        S_RUN, S_DRAIN: begin
          if (i_wire_start || stall[TIMEOUT_BITS-1]) begin
            // Any error discards buffered words; the consumer can no longer trust the job.
            state  <= S_ERROR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            stall  <= '0;
            if (i_wire_start)       err_type <= 3'd4;
            else if (level == '0)   err_type <= 3'd2;
            else                    err_type <= 3'd3;
          end else if (state == S_RUN && in_last) begin
            state <= out_last ? S_DONE : S_DRAIN;
          end else if (state == S_DRAIN && out_last) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_read_fifo.sv
// Bench for painterengine_gpu_read_fifo: job table plus hand sequences, scoreboard on the output stream.
module tb_painterengine_gpu_read_fifo;

  localparam int DL2 = 4;
  localparam int TOB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   job_len = '0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_next;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_next = 1'b0;
  logic [DL2:0]  level;
  logic          done;
  logic          error;
  logic [2:0]    error_type;

  int n_cmp = 0;
  int n_err = 0;
  int pushes = 0;
  logic [31:0] sb [$];

  painterengine_gpu_read_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT_BITS(TOB)) dut (
    .i_wire_clock     (clk),
    .i_wire_reset     (reset),
    .i_wire_start     (start),
    .i_wire_length    (job_len),
    .i_wire_data      (in_data),
    .i_wire_data_valid(in_valid),
    .o_wire_data_next (in_next),
    .o_wire_data      (out_data),
    .o_wire_data_valid(out_valid),
    .i_wire_data_next (out_next),
    .o_wire_level     (level),
    .o_wire_done      (done),
    .o_wire_error     (error),
    .o_wire_error_type(error_type)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers are sampled mid-cycle, when inputs and register-driven outputs are settled.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_next) begin
        sb.push_back(in_data);
        pushes++;
      end
      if (out_valid && out_next) begin
        if (sb.size() == 0) check("pop_with_empty_scoreboard", 32'd1, 32'd0);
        else check("out_word", out_data, sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] word(input int job, input int i);
    return (32'h11 * (i + 1)) + (job << 16);
  endfunction

  task automatic pulse_start(input logic [31:0] len);
    sb.delete();
    pushes = 0;
    in_valid = 1'b0;
    start = 1'b1;
    job_len = len;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] len;
    int          n_send;
    int          v_pct;
    int          r_pct;
    logic        exp_done;
    logic        exp_err;
    logic [2:0]  exp_type;
    int          exp_pushes;
  } job_t;

  task automatic run_job(input job_t j, input int idx);
    int   sent;
    logic fin;
    sent = 0;
    fin  = 1'b0;
    pulse_start(j.len);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (done || error) fin = 1'b1;
      else begin
        if (sent < j.n_send && $urandom_range(99) < j.v_pct) begin
          in_valid = 1'b1;
          in_data  = word(idx, sent);
          if (in_next) sent++;
        end else begin
          in_valid = 1'b0;
        end
        out_next = ($urandom_range(99) < j.r_pct);
        tick();
      end
    end
    in_valid = 1'b0;
    out_next = 1'b0;
    check($sformatf("job%0d_finished", idx), 32'(fin), 32'd1);
    check($sformatf("job%0d_done", idx), 32'(done), 32'(j.exp_done));
    check($sformatf("job%0d_error", idx), 32'(error), 32'(j.exp_err));
    check($sformatf("job%0d_error_type", idx), 32'(error_type), 32'(j.exp_type));
    check($sformatf("job%0d_level", idx), 32'(level), 32'd0);
    check($sformatf("job%0d_pushes", idx), 32'(pushes), 32'(j.exp_pushes));
    check($sformatf("job%0d_valid_off", idx), 32'(out_valid), 32'd0);
    check($sformatf("job%0d_next_off", idx), 32'(in_next), 32'd0);
  endtask

  job_t jobs [8];

  initial begin
    int sent;
    int pops;
    logic pop_now;
    logic fin;

    jobs[0] = '{32'd5,  5,  100, 100, 1'b1, 1'b0, 3'd0, 5};
    jobs[1] = '{32'd8,  12, 50,  50,  1'b1, 1'b0, 3'd0, 8};
    jobs[2] = '{32'd0,  0,  100, 100, 1'b0, 1'b1, 3'd1, 0};
    jobs[3] = '{32'd3,  3,  100, 100, 1'b1, 1'b0, 3'd0, 3};
    jobs[4] = '{32'd4,  2,  100, 100, 1'b0, 1'b1, 3'd2, 2};
    jobs[5] = '{32'd4,  4,  100, 0,   1'b0, 1'b1, 3'd3, 4};
    jobs[6] = '{32'd17, 17, 70,  30,  1'b1, 1'b0, 3'd0, 17};
    jobs[7] = '{32'd1,  1,  100, 100, 1'b1, 1'b0, 3'd0, 1};

    // Reset state.
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_next", 32'(in_next), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_type", 32'(error_type), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    reset = 1'b0;
    tick();

    // Back-to-back length 5: latency of first word and done timing.
    out_next = 1'b1;
    pulse_start(32'd5);
    check("b_next_in_run", 32'(in_next), 32'd1);
    check("b_no_early_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    check("b_first_valid", 32'(out_valid), 32'd1);
    check("b_first_data", out_data, 32'h11);
    sent = 1;
    pops = 0;
    fin  = 1'b0;
    for (int cyc = 0; cyc < 50 && !fin; cyc++) begin
      pop_now = out_valid && out_next;
      if (sent < 5) begin
        in_valid = 1'b1;
        in_data  = 32'h11 * (sent + 1);
        if (in_next) sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (pop_now) begin
        pops++;
        if (pops == 4) check("b_done_not_early", 32'(done), 32'd0);
        if (pops == 5) begin
          check("b_done_after_last_pop", 32'(done), 32'd1);
          check("b_level_zero", 32'(level), 32'd0);
          fin = 1'b1;
        end
      end
    end
    check("b_finished", 32'(fin), 32'd1);
    in_valid = 1'b0;
    out_next = 1'b0;

    // Length 20 against a stalled consumer: fill to 16, then release.
    pulse_start(32'd20);
    sent = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid = 1'b1;
      in_data  = 32'hC000_0000 + sent;
      if (in_next) sent++;
      tick();
    end
    check("c_level_full", 32'(level), 32'd16);
    check("c_next_low_full", 32'(in_next), 32'd0);
    check("c_pushes_at_full", 32'(pushes), 32'd16);
    check("c_head_held", out_data, 32'hC000_0000);
    check("c_valid_held", 32'(out_valid), 32'd1);
    out_next = 1'b1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (done) fin = 1'b1;
      else begin
        if (sent < 20) begin
          in_valid = 1'b1;
          in_data  = 32'hC000_0000 + sent;
          if (in_next) sent++;
        end else begin
          in_valid = 1'b0;
        end
        tick();
      end
    end
    in_valid = 1'b0;
    out_next = 1'b0;
    check("c_done", 32'(fin), 32'd1);
    check("c_pushes_total", 32'(pushes), 32'd20);
    check("c_scoreboard_empty", 32'(sb.size()), 32'd0);

    // Table of jobs with random gaps, zero length, and both timeouts.
    for (int k = 0; k < 8; k++) run_job(jobs[k], k);

    // Reset in the middle of a job with three words buffered.
    pulse_start(32'd10);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hD000_0000 + i;
      tick();
    end
    in_valid = 1'b0;
    check("d_level_3", 32'(level), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("d_valid", 32'(out_valid), 32'd0);
    check("d_next", 32'(in_next), 32'd0);
    check("d_done", 32'(done), 32'd0);
    check("d_error", 32'(error), 32'd0);
    check("d_level", 32'(level), 32'd0);
    run_job('{32'd2, 2, 100, 100, 1'b1, 1'b0, 3'd0, 2}, 9);

    // Start pulsed during a running job.
    pulse_start(32'd6);
    in_valid = 1'b1;
    in_data  = 32'hE000_0000;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    job_len = 32'd6;
    tick();
    start = 1'b0;
    check("e_error", 32'(error), 32'd1);
    check("e_type", 32'(error_type), 32'd4);
    check("e_valid", 32'(out_valid), 32'd0);
    check("e_next", 32'(in_next), 32'd0);
    check("e_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_read_fifo.md
Name: painterengine_gpu_read_fifo

Overview:
- Elastic buffer directly downstream of one channel of the GPU DMA reader.
- Accepts 32-bit words using the reader's data/valid/next handshake and holds them in a FIFO.
- Presents them first-word-fall-through to the next consumer, typically the GPU pixel/compute stage.
- Counts words against a programmed length and reports done/error so the GPU controller can sequence jobs.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 words (default 16).
TIMEOUT_BITS, 19, stall counter width; error when bit [TIMEOUT_BITS-1] sets (default 2^18 stalled cycles).

Ports:
i_wire_clock  input  1  the single clock; all state on rising edge.
i_wire_reset  input  1  synchronous, active-high reset.
i_wire_start  input  1  one-cycle pulse; latches i_wire_length and begins a job.
i_wire_length  input  32  job length in 32-bit words.
i_wire_data  input  32  word from the reader channel.
i_wire_data_valid  input  1  reader word valid.
o_wire_data_next  output  1  ready to reader; push occurs when i_wire_data_valid && o_wire_data_next.
o_wire_data  output  32  FIFO head word.
o_wire_data_valid  output  1  FIFO non-empty.
i_wire_data_next  input  1  consumer ready; pop occurs when o_wire_data_valid && i_wire_data_next.
o_wire_level  output  DEPTH_LOG2+1  current occupancy.
o_wire_done  output  1  job complete.
o_wire_error  output  1  in error state.
o_wire_error_type  output  3  0 ok, 1 zero length, 2 input timeout, 3 output timeout, 4 start while busy.

Behaviour:
- Reset (synchronous, i_wire_reset=1 at a clock edge):
  - state IDLE; pointers, level, in/out counters and stall counter cleared.
  - o_wire_data_next=0, o_wire_data_valid=0, o_wire_done=0, o_wire_error=0, o_wire_error_type=0, o_wire_level=0.
  - o_wire_data is don't-care while empty.
  - Reset mid-job discards all buffered words.
- States: IDLE, RUN, DRAIN, DONE, ERROR.
- IDLE:
  - start with length!=0 -> RUN; length latched; counters 0.
  - start with length==0 -> ERROR, type 1.
- RUN:
  - o_wire_data_next = !full && (in_count < length), combinational from registers, never from i_wire_data_valid.
  - Each push increments in_count (32-bit).
  - When in_count reaches length, go to DRAIN on that push's edge.
- DRAIN:
  - o_wire_data_next=0.
  - When out_count reaches length (pop on that edge) -> DONE.
  - If the final pop coincides with the final push in RUN, go directly RUN -> DONE.
- DONE:
  - o_wire_done=1, FIFO empty, o_wire_error_type=0.
  - start -> RUN with the new length, or ERROR type 1 if the new length is 0.
- ERROR:
  - o_wire_error=1, sticky; outputs valid/next forced 0.
  - Only i_wire_reset or start clears it.
  - start restarts as from IDLE, flushing the FIFO.
- start while in RUN or DRAIN -> ERROR, type 4; the FIFO is flushed.
- FIFO rules:
  - Storage is a register/RAM array; read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Level tracks simultaneous push and pop (unchanged when both occur).
  - Write latency is 1: a word pushed into an empty FIFO appears on o_wire_data/o_wire_data_valid the following cycle. No same-cycle bypass.
  - When full, next=0 even if a pop occurs the same cycle; no simultaneous push at full.
  - Simultaneous push and pop at level 1 is legal; the head advances correctly.
  - o_wire_data and o_wire_data_valid are stable while valid && !next; the head changes only on a pop.
- Timeouts (RUN/DRAIN only):
  - The stall counter clears on any push or pop.
  - It increments when no transfer occurs and at least one side is blocked waiting:
    - RUN with next=1 and no valid (input wait), or
    - level>0 with no consumer ready (output wait).
  - On the MSB setting: ERROR, type 2 if the FIFO is empty, otherwise type 3.
  - The counter is held at 0 in IDLE/DONE/ERROR.
- Counters compare as unsigned 32-bit; length up to 2^32-1 is supported with no wrap of in_count/out_count before length.

Test Plan:
- Reset, then start with length=5, reader sends 0x11..0x55 back-to-back, consumer always ready -> first o_wire_data_valid one cycle after the first push; words output in order; o_wire_done one cycle after the 5th pop; level returns to 0.
- Length=20, consumer held not-ready -> 16 pushes accepted, level=16, o_wire_data_next=0. Release the consumer -> remaining 4 words accepted as space frees; 20 pops total, then done.
- Length=8, random valid/next gaps (50%) -> output sequence equals input sequence; no push after in_count=8 even though the reader keeps valid high; DRAIN then DONE.
- Start with length=0 -> o_wire_error=1, type=1. Then start with length=3 -> RUN; 3 words -> done.
- Length=4, only 2 words sent then valid held low for 2^18 cycles -> the FIFO drains to empty, then ERROR type 2. Separate run: words buffered, consumer never ready -> ERROR type 3.
- Mid-job (level=3) assert i_wire_reset one cycle -> next cycle all outputs 0, level=0; start with length=2 -> normal completion. Start pulsed during RUN -> ERROR type 4.
